control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The module SHALL have parameter INSTR_W, default 16, meaning instruction word width.
REQ-002 The module SHALL have parameter STATUS_W, default 8, meaning status register width; condition codes index it.
REQ-003 The module SHALL have parameter MAX_EXEC, default 4, meaning maximum execute cycles per instruction (2..8).
REQ-004 Port clk  in  1  single system clock, rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port instr  in  INSTR_W  fetched instruction word.
REQ-007 Port instr_valid  in  1  instruction memory ready; fetch completes only when high.
REQ-008 Port cond_field  in  4  decoded condition code.
REQ-009 Port exec_len  in  $clog2(MAX_EXEC+1)  execute cycles required; sampled at fetch completion.
REQ-010 Port status  in  STATUS_W  status flags.
REQ-011 Port stop_req, stack_overflow, jump_taken  in  1 each  decoded halt, overflow, taken branch.
REQ-012 Port state  out  2  FETCH=0, EXEC=1, HALT=2, IRQ=3.
REQ-013 Port exec_idx  out  $clog2(MAX_EXEC)  current execute cycle, 0-based.
REQ-014 Port ir  out  INSTR_W  latched instruction register.
REQ-015 Port cond_pass, pc_cnt_en, flush, halted  out  1 each.

Function
REQ-016 FETCH: pc_cnt_en=1 and instr_valid=1 together SHALL latch instr into ir, latch exec_len (0 treated as 1), and enter EXEC with exec_idx=0; instr_valid=0 SHALL hold FETCH with pc_cnt_en=1 and ir unchanged (wait state).
REQ-017 EXEC SHALL last exactly the latched exec_len cycles, exec_idx incrementing by 1 per cycle, then return to FETCH; exec_len > MAX_EXEC SHALL saturate at MAX_EXEC.
REQ-018 cond_pass SHALL be combinational: codes 0..7 select status[code]; codes 8..15 select ~status[code-8]; code 6 SHALL be 1 always; code 14 SHALL be 1; indices >= STATUS_W SHALL give 1.
REQ-019 cond_pass=0 during EXEC with exec_idx=0 SHALL terminate EXEC after that cycle (instruction annulled, single cycle).
REQ-020 pc_cnt_en SHALL be 1 in FETCH and in the final EXEC cycle unless jump_taken and cond_pass are both 1 in that cycle.
REQ-021 jump_taken and cond_pass both 1 in any EXEC cycle SHALL pulse flush for one cycle and force FETCH next cycle, overriding remaining exec cycles.
REQ-022 stop_req and cond_pass in EXEC, or stack_overflow in any state, SHALL enter HALT next cycle; HALT has halted=1, pc_cnt_en=0, and is left only by reset.
REQ-023 Simultaneous halt and jump SHALL give HALT priority; flush SHALL still pulse.

Reset
REQ-024 reset SHALL, on the clock edge, set state=FETCH, exec_idx=0, ir=0, flush=0, halted=0, irq_ack=0, latched exec_len=1; reset mid-EXEC or in HALT SHALL abandon the instruction with no further outputs.

Configuration
REQ-025 Macro SEQ_IRQ_EN SHALL add ports irq (in 1) and irq_ack (out 1).
REQ-026 With SEQ_IRQ_EN: irq=1 when EXEC completes SHALL enter IRQ for one cycle (irq_ack=1, pc_cnt_en=0), then FETCH.
REQ-027 With SEQ_IRQ_EN: halt SHALL beat irq, and irq SHALL be ignored in HALT and FETCH.
REQ-028 Without SEQ_IRQ_EN: the ports SHALL be absent and state 3 unreachable.

Structure
REQ-029 The state encoding enum and condition-code constants (ALWAYS=6) SHALL live in shared package cpu_pkg.
REQ-030 Condition evaluation SHALL be sub-module cond_eval (cond_field, status -> cond_pass), parametrised by STATUS_W.

Verification
REQ-031 exec_len=3, cond_field=6, instr_valid=1 -> states FETCH,EXEC,EXEC,EXEC,FETCH; exec_idx 0,1,2; pc_cnt_en high in FETCH and 3rd EXEC.
REQ-032 instr_valid low 2 cycles -> FETCH held 3 cycles, ir loaded only on 3rd; instr=16'hC0A6 appears on ir.
REQ-033 cond_field=8, status[0]=1, exec_len=4 -> single EXEC cycle, then FETCH.
REQ-034 jump_taken=1 at exec_idx=1 of 4 -> flush pulse, FETCH next cycle, pc_cnt_en=0 in that cycle.
REQ-035 stack_overflow during FETCH -> HALT, halted=1; reset -> FETCH, ir=0.
REQ-036 SEQ_IRQ_EN, irq=1 at final EXEC -> one IRQ cycle with irq_ack=1, then FETCH; same with stop_req -> HALT, no irq_ack.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the control sequencer: the state
//                encoding (also the value driven on the 'state' port) and
//                the condition-code constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Sequencer states; the numeric values are visible on the 'state' port.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2,
        ST_IRQ   = 2'd3
    } seq_state_t;

    // Condition codes: bit 3 selects inverted polarity, bits 2:0 select the
    // status flag. Both 6 and 14 are unconditional.
    localparam logic [3:0] COND_ALWAYS     = 4'd6;
    localparam logic [3:0] COND_ALWAYS_ALT = 4'd14;
    localparam int         COND_INV_BIT    = 3;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : cond_eval
//  Description : Combinational condition-code evaluator.
//                Codes 0..7 pass status[code], codes 8..15 pass
//                ~status[code-8]. Codes 6/14 always pass, as does any code
//                whose flag index lies beyond the status register.
//  Ports       : cond_field (in 4)        condition code
//                status     (in STATUS_W) status flags
//                cond_pass  (out 1)       condition result
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
    import cpu_pkg::*;
#(
    parameter int STATUS_W = 8
) (
    input  logic [3:0]          cond_field,
    input  logic [STATUS_W-1:0] status,
    output logic                cond_pass
);

    logic w_hit;   // flag index exists in the status register
    logic w_flag;  // selected flag, true polarity

    always_comb begin
        w_hit  = 1'b0;
        w_flag = 1'b0;
        // Only the first eight flags are addressable by a 3-bit index.
        for (int i = 0; i < STATUS_W && i < 8; i++) begin
            if (cond_field[2:0] == 3'(i)) begin
                w_hit  = 1'b1;
                w_flag = status[i];
            end
        end
    end

    always_comb begin
        if (cond_field[2:0] == COND_ALWAYS[2:0]) begin
            cond_pass = 1'b1;
        end else if (!w_hit) begin
            cond_pass = 1'b1;
        end else begin
            cond_pass = w_flag ^ cond_field[COND_INV_BIT];
        end
    end

endmodule : cond_eval
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Fetch/execute control sequencer. Latches an instruction,
//                runs it for a variable number of execute cycles, and
//                handles annulment, taken jumps (flush) and halting.
//                Optional interrupt support: define SEQ_IRQ_EN to add the
//                irq/irq_ack ports and the single-cycle IRQ state.
//  Ports       : clk, reset (sync, active high)
//                instr, instr_valid, cond_field, exec_len, status,
//                stop_req, stack_overflow, jump_taken       -> inputs
//                state, exec_idx, ir, cond_pass, pc_cnt_en,
//                flush, halted                              -> outputs
//                irq (in), irq_ack (out)                    -> SEQ_IRQ_EN only
//  Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int INSTR_W  = 16,
    parameter int STATUS_W = 8,
    parameter int MAX_EXEC = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [INSTR_W-1:0]            instr,
    input  logic                          instr_valid,
    input  logic [3:0]                    cond_field,
    input  logic [$clog2(MAX_EXEC+1)-1:0] exec_len,
    input  logic [STATUS_W-1:0]           status,
    input  logic                          stop_req,
    input  logic                          stack_overflow,
    input  logic                          jump_taken,
    output logic [1:0]                    state,
    output logic [$clog2(MAX_EXEC)-1:0]   exec_idx,
    output logic [INSTR_W-1:0]            ir,
    output logic                          cond_pass,
    output logic                          pc_cnt_en,
    output logic                          flush,
    output logic                          halted
`ifdef SEQ_IRQ_EN
    ,
    input  logic                          irq,
    output logic                          irq_ack
`endif
);

    localparam int LEN_W = $clog2(MAX_EXEC + 1);
    localparam int IDX_W = $clog2(MAX_EXEC);

    seq_state_t         r_state;
    seq_state_t         w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_next;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   w_len_in;
    logic [INSTR_W-1:0] r_ir;

    logic w_irq;
    logic w_in_exec;
    logic w_last;
    logic w_annul;
    logic w_jump;
    logic w_halt;
    logic w_load;

    cond_eval #(
        .STATUS_W (STATUS_W)
    ) u_cond_eval (
        .cond_field (cond_field),
        .status     (status),
        .cond_pass  (cond_pass)
    );

`ifdef SEQ_IRQ_EN
    assign w_irq   = irq;
    assign irq_ack = (r_state == ST_IRQ);
`else
    assign w_irq   = 1'b0;
`endif

    // Length sampled at fetch: zero means one cycle, oversize saturates.
    always_comb begin
        if (exec_len == '0) begin
            w_len_in = LEN_W'(1);
        end else if (exec_len > LEN_W'(MAX_EXEC)) begin
            w_len_in = LEN_W'(MAX_EXEC);
        end else begin
            w_len_in = exec_len;
        end
    end

    assign w_in_exec = (r_state == ST_EXEC);
    assign w_last    = w_in_exec && (LEN_W'(r_idx) == (r_len - LEN_W'(1)));
    // A failed condition on the first execute cycle annuls the instruction.
    assign w_annul   = w_in_exec && (r_idx == '0) && !cond_pass;
    assign w_jump    = w_in_exec && jump_taken && cond_pass;
    assign w_halt    = stack_overflow || (w_in_exec && stop_req && cond_pass);
    assign w_load    = (r_state == ST_FETCH) && instr_valid && !stack_overflow;

    // Next-state logic; priority in EXEC is halt > jump > normal completion.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            ST_FETCH: begin
                if (stack_overflow) begin
                    w_state_next = ST_HALT;
                end else if (instr_valid) begin
                    w_state_next = ST_EXEC;
                    w_idx_next   = '0;
                end
            end
            ST_EXEC: begin
                if (w_halt) begin
                    w_state_next = ST_HALT;
                    w_idx_next   = '0;
                end else if (w_jump) begin
                    w_state_next = ST_FETCH;
                    w_idx_next   = '0;
                end else if (w_last || w_annul) begin
                    w_state_next = w_irq ? ST_IRQ : ST_FETCH;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next   = r_idx + IDX_W'(1);
                end
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            ST_IRQ: begin
                w_state_next = stack_overflow ? ST_HALT : ST_FETCH;
            end
            default: begin
                w_state_next = ST_FETCH;
                w_idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_idx   <= '0;
            r_ir    <= '0;
            r_len   <= LEN_W'(1);
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            if (w_load) begin
                r_ir  <= instr;
                r_len <= w_len_in;
            end
        end
    end

    assign state     = r_state;
    assign exec_idx  = r_idx;
    assign ir        = r_ir;
    assign flush     = w_jump;
    assign halted    = (r_state == ST_HALT);
    assign pc_cnt_en = (r_state == ST_FETCH) || (w_last && !w_jump);

endmodule : control_sequencer
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Self-checking bench for control_sequencer: directed
//                scenarios followed by random stimulus compared against a
//                cycle-level reference model kept in the bench.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    localparam int INSTR_W  = 16;
    localparam int STATUS_W = 8;
    localparam int MAX_EXEC = 4;
`ifdef SEQ_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] instr;
        logic        valid;
        logic [3:0]  cond;
        logic [2:0]  len;
        logic [7:0]  status;
        logic        stop;
        logic        ovf;
        logic        jump;
        logic        irq;
    } stim_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic [3:0]  cond_field;
    logic [2:0]  exec_len;
    logic [7:0]  status;
    logic        stop_req;
    logic        stack_overflow;
    logic        jump_taken;
    logic [1:0]  state;
    logic [1:0]  exec_idx;
    logic [15:0] ir;
    logic        cond_pass;
    logic        pc_cnt_en;
    logic        flush;
    logic        halted;
    logic        irq;
    logic        irq_ack;

    int checks = 0;
    int errors = 0;

    // Reference model: mode (0 fetch, 1 exec, 2 halt, 3 irq), cycles spent
    // on the current instruction, its effective length, and the ir image.
    int          m_mode;
    int          m_done;
    int          m_len;
    logic [15:0] m_ir;

    control_sequencer #(
        .INSTR_W  (INSTR_W),
        .STATUS_W (STATUS_W),
        .MAX_EXEC (MAX_EXEC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .cond_field     (cond_field),
        .exec_len       (exec_len),
        .status         (status),
        .stop_req       (stop_req),
        .stack_overflow (stack_overflow),
        .jump_taken     (jump_taken),
        .state          (state),
        .exec_idx       (exec_idx),
        .ir             (ir),
        .cond_pass      (cond_pass),
        .pc_cnt_en      (pc_cnt_en),
        .flush          (flush),
        .halted         (halted)
`ifdef SEQ_IRQ_EN
        ,
        .irq            (irq),
        .irq_ack        (irq_ack)
`endif
    );

`ifndef SEQ_IRQ_EN
    assign irq_ack = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic stim_t mk(input logic [15:0] i, input logic v, input logic [3:0] c,
                                 input logic [2:0] l, input logic [7:0] s = 8'h00,
                                 input logic stp = 1'b0, input logic ov = 1'b0,
                                 input logic jmp = 1'b0, input logic iq = 1'b0);
        stim_t t;
        t.instr = i; t.valid = v; t.cond = c; t.len = l; t.status = s;
        t.stop = stp; t.ovf = ov; t.jump = jmp; t.irq = iq;
        return t;
    endfunction

    function automatic bit ref_cond(input int code, input logic [7:0] st);
        int pos;
        pos = code % 8;
        if (pos == 6 || pos >= STATUS_W) return 1'b1;
        return (code >= 8) ? !st[pos] : st[pos];
    endfunction

    function automatic int eff_len(input int l);
        if (l == 0) return 1;
        if (l > MAX_EXEC) return MAX_EXEC;
        return l;
    endfunction

    // Drive one cycle of inputs at the falling edge and check every output
    // of that cycle against the model.
    task automatic apply(input stim_t s);
        bit cp, fin, jmp;
        @(negedge clk);
        instr = s.instr; instr_valid = s.valid; cond_field = s.cond;
        exec_len = s.len; status = s.status; stop_req = s.stop;
        stack_overflow = s.ovf; jump_taken = s.jump; irq = s.irq;
        #1;
        cp  = ref_cond(int'(s.cond), s.status);
        fin = (m_mode == 1) && (m_done == m_len - 1);
        jmp = (m_mode == 1) && s.jump && cp;
        chk("state",     32'(state),     32'(m_mode));
        chk("exec_idx",  32'(exec_idx),  32'((m_mode == 1) ? m_done : 0));
        chk("ir",        32'(ir),        32'(m_ir));
        chk("cond_pass", 32'(cond_pass), 32'(cp));
        chk("flush",     32'(flush),     32'(jmp));
        chk("pc_cnt_en", 32'(pc_cnt_en), 32'((m_mode == 0) || (fin && !jmp)));
        chk("halted",    32'(halted),    32'(m_mode == 2));
        if (IRQ_EN) chk("irq_ack", 32'(irq_ack), 32'(m_mode == 3));
    endtask

    // Advance the model across the rising edge using the inputs held now.
    task automatic commit();
        bit cp;
        cp = ref_cond(int'(cond_field), status);
        case (m_mode)
            0: begin
                if (stack_overflow) m_mode = 2;
                else if (instr_valid) begin
                    m_mode = 1; m_done = 0; m_ir = instr;
                    m_len = eff_len(int'(exec_len));
                end
            end
            1: begin
                if (stack_overflow || (stop_req && cp)) m_mode = 2;
                else if (jump_taken && cp) m_mode = 0;
                else if (m_done == m_len - 1 || (m_done == 0 && !cp))
                    m_mode = (IRQ_EN && irq) ? 3 : 0;
                else m_done++;
            end
            2: m_mode = 2;
            default: m_mode = stack_overflow ? 2 : 0;
        endcase
    endtask

    task automatic cyc(input stim_t s);
        apply(s);
        commit();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        instr = '0; instr_valid = 1'b0; cond_field = '0; exec_len = '0;
        status = '0; stop_req = 1'b0; stack_overflow = 1'b0;
        jump_taken = 1'b0; irq = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_mode = 0; m_done = 0; m_len = 1; m_ir = '0;
    endtask

    initial begin
        stim_t s;
        reset = 1'b1;
        instr = '0; instr_valid = 1'b0; cond_field = '0; exec_len = '0;
        status = '0; stop_req = 1'b0; stack_overflow = 1'b0;
        jump_taken = 1'b0; irq = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_idx",   32'(exec_idx), 32'd0);
        chk("rst_ir",    32'(ir), 32'd0);
        chk("rst_halt",  32'(halted), 32'd0);

        // Three-cycle instruction, unconditional.
        s = mk(16'h1234, 1'b1, 4'd6, 3'd3);
        apply(s); chk("seq3_f_pc", 32'(pc_cnt_en), 32'd1); commit();
        apply(s); chk("seq3_e0", 32'(state), 32'd1); chk("seq3_e0_pc", 32'(pc_cnt_en), 32'd0); commit();
        apply(s); chk("seq3_e1_idx", 32'(exec_idx), 32'd1); commit();
        apply(s); chk("seq3_e2_idx", 32'(exec_idx), 32'd2); chk("seq3_e2_pc", 32'(pc_cnt_en), 32'd1); commit();
        apply(mk(16'h0, 1'b0, 4'd6, 3'd1)); chk("seq3_back", 32'(state), 32'd0); commit();

        // Wait states: ir only loads once instr_valid rises.
        cyc(mk(16'hC0A6, 1'b0, 4'd6, 3'd1));
        apply(mk(16'hC0A6, 1'b0, 4'd6, 3'd1)); chk("wait_ir", 32'(ir), 32'h1234); commit();
        cyc(mk(16'hC0A6, 1'b1, 4'd6, 3'd1));
        apply(mk(16'h0, 1'b0, 4'd6, 3'd1)); chk("wait_ir_load", 32'(ir), 32'hC0A6); commit();

        // Annul: code 8 with status[0]=1 fails on the first execute cycle.
        cyc(mk(16'h0008, 1'b1, 4'd8, 3'd4, 8'h01));
        cyc(mk(16'h0, 1'b0, 4'd8, 3'd4, 8'h01));
        apply(mk(16'h0, 1'b0, 4'd6, 3'd1)); chk("annul_fetch", 32'(state), 32'd0); commit();

        // Jump at exec_idx 1 of 4.
        cyc(mk(16'h0BEE, 1'b1, 4'd6, 3'd4));
        cyc(mk(16'h0, 1'b0, 4'd6, 3'd4));
        apply(mk(16'h0, 1'b0, 4'd6, 3'd4, 8'h00, 1'b0, 1'b0, 1'b1));
        chk("jump_flush", 32'(flush), 32'd1); chk("jump_pc", 32'(pc_cnt_en), 32'd0); commit();
        apply(mk(16'h0, 1'b0, 4'd6, 3'd1)); chk("jump_fetch", 32'(state), 32'd0); commit();

        // Stack overflow while fetching, then recover by reset.
        cyc(mk(16'h0, 1'b0, 4'd6, 3'd1, 8'h00, 1'b0, 1'b1));
        apply(mk(16'h0, 1'b1, 4'd6, 3'd1)); chk("ovf_halted", 32'(halted), 32'd1); commit();
        do_reset();
        chk("ovf_rst_state", 32'(state), 32'd0);
        chk("ovf_rst_ir", 32'(ir), 32'd0);

`ifdef SEQ_IRQ_EN
        cyc(mk(16'h0A0A, 1'b1, 4'd6, 3'd2));
        cyc(mk(16'h0, 1'b0, 4'd6, 3'd2));
        cyc(mk(16'h0, 1'b0, 4'd6, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
        apply(mk(16'h0, 1'b0, 4'd6, 3'd1)); chk("irq_state", 32'(state), 32'd3);
        chk("irq_ack", 32'(irq_ack), 32'd1); chk("irq_pc", 32'(pc_cnt_en), 32'd0); commit();
        apply(mk(16'h0, 1'b0, 4'd6, 3'd1)); chk("irq_fetch", 32'(state), 32'd0); commit();
        cyc(mk(16'h0B0B, 1'b1, 4'd6, 3'd2));
        cyc(mk(16'h0, 1'b0, 4'd6, 3'd2));
        cyc(mk(16'h0, 1'b0, 4'd6, 3'd2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1));
        apply(mk(16'h0, 1'b0, 4'd6, 3'd1)); chk("stop_halt", 32'(state), 32'd2);
        chk("stop_noack", 32'(irq_ack), 32'd0); commit();
        do_reset();
`endif

        // Random phase against the model.
        for (int n = 0; n < 600; n++) begin
            if (m_mode == 2 && $urandom_range(0, 2) == 0) begin
                do_reset();
            end else begin
                s.instr  = 16'($urandom);
                s.valid  = ($urandom_range(0, 3) != 0);
                s.cond   = 4'($urandom_range(0, 15));
                s.len    = 3'($urandom_range(0, 7));
                s.status = 8'($urandom);
                s.stop   = ($urandom_range(0, 15) == 0);
                s.ovf    = ($urandom_range(0, 49) == 0);
                s.jump   = ($urandom_range(0, 7) == 0);
                s.irq    = ($urandom_range(0, 3) == 0);
                cyc(s);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_control_sequencer
`default_nettype wire
